cnn_out_relu_pool: RTL and testbench
====================================

Name: cnn_out_relu_pool

Overview:
- Downstream stage of the CNN accelerator core.
- Consumes the 16-bit CNN_OUT result stream and applies ReLU.
- Max-pools each group of POOL_N consecutive valid results.
- Buffers pooled values in a small FIFO, presented to the next layer or readout through a valid/ready handshake.

Parameters:
- DATA_W, 16, width of CNN_OUT and of pooled output.
- POOL_N, 4, number of consecutive valid samples per max-pool window (>=2).
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2).
- SIGNED_IN, 1, 1 = In_Data is two's complement and ReLU clamps negatives; 0 = unsigned, ReLU is pass-through.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset.
- Clear  input  1  synchronous flush of pool state and FIFO.
- In_Valid  input  1  In_Data holds a new CNN result this cycle.
- In_Data  input  DATA_W  CNN_OUT sample.
- Out_Valid  output  1  FIFO non-empty, Out_Data valid.
- Out_Ready  input  1  consumer accepts Out_Data this cycle.
- Out_Data  output  DATA_W  head of FIFO.
- Fifo_Count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- Pool_Idx  output  $clog2(POOL_N)  samples already taken in current window.
- Overflow  output  1  sticky: a pooled result was dropped.

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values while Rst is high:
  - Out_Valid=0, Out_Data=0, Fifo_Count=0, Pool_Idx=0, Overflow=0.
  - Running-max register = 0.
  - FIFO pointers = 0.
- Reset mid-window discards the partial window and all FIFO contents.
- ReLU: r = (SIGNED_IN && In_Data[DATA_W-1]) ? 0 : In_Data. Comparison is unsigned on r, since r >= 0 after ReLU.
- Pooling, evaluated at each edge with In_Valid=1:
  - Pool_Idx==0: max <= r.
  - Otherwise: max <= (r > max) ? r : max.
  - Pool_Idx < POOL_N-1: Pool_Idx increments.
  - Pool_Idx == POOL_N-1: Pool_Idx wraps to 0 and pooled = max(max, r) is pushed into the FIFO at the same edge.
  - In_Valid=0: no state change. Gaps between samples are allowed and do not break the window.
- Latency: Out_Valid rises on the edge that captures the final sample of a window (FIFO empty case). Out_Data is visible the cycle after that sample is presented.
- Input has no backpressure, since the upstream core has no ready.
- Push when FIFO full:
  - With Out_Ready=0: the pooled value is dropped and Overflow is set; it stays set until Rst or Clear.
  - With Out_Valid=1 and Out_Ready=1 in the same cycle: pop and push both occur, nothing is dropped, and Fifo_Count stays at FIFO_DEPTH.
- Pop occurs when Out_Valid && Out_Ready; Out_Ready while empty is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: Fifo_Count is unchanged.
- Ordering is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- Out_Data is a registered/array-read head. It is stable while Out_Valid=1 and Out_Ready=0.
- Clear, synchronous:
  - Same effect as reset on all state, including Overflow.
  - Takes priority over In_Valid and Out_Ready in the same cycle, so a sample presented with Clear is discarded.

Decomposition:
- Shared package cnn_pkg:
  - CNN_DATA_W=16 and CNN_POOL_N=4 constants.
  - relu function parameterised by signedness.
  - Also reused by the upstream core's testbench checker.
- One natural sub-module: cnn_sync_fifo, parameterised by width and depth.
  - Provides push, pop, full, empty, count and head.
  - Implements the push-on-full-with-pop rule internally.
- The pooling counter, max register and overflow flag stay in cnn_out_relu_pool.

Test Plan:
1. Rst high 2 cycles, then In_Valid with In_Data 1,2,3,4 on consecutive cycles, Out_Ready=1 -> one output 4, Out_Valid high exactly 1 cycle, Fifo_Count back to 0, Pool_Idx 0.
2. Negative clamp, SIGNED_IN=1, In_Data 0xFFFB,0xFFFF,0x8000,0xFFFE -> output 0x0000. Then 0x8000,0x0005,0x7FFF,0x0003 -> output 0x7FFF.
3. Gapped input: samples 9,_,_,2,_,7,11 with In_Valid low at the "_" slots -> single output 11, produced on the edge capturing 11.
4. Overflow: Out_Ready=0, 9 windows with maxima 10..18 -> Fifo_Count=8 and Overflow=1. Then Out_Ready=1 drains 10..17 in order, and Overflow stays 1 until Clear.
5. Full with push+pop: FIFO full, Out_Ready=1 in the same cycle a window of max 50 completes -> head popped, 50 appended, Fifo_Count=8, Overflow stays 0.
6. Rst asserted asynchronously after 2 samples of a window with 3 entries queued -> all outputs 0 immediately. Post-reset samples 6,1,1,1 -> output 6 (stale partial window not merged).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN accelerator output path.
package cnn_pkg;

  localparam int unsigned CNN_DATA_W = 16;
  localparam int unsigned CNN_POOL_N = 4;

  typedef logic [CNN_DATA_W-1:0] cnn_data_t;

  // ReLU on a CNN_OUT sample; unsigned data passes straight through.
  function automatic cnn_data_t relu(input cnn_data_t d, input bit is_signed);
    return (is_signed && d[CNN_DATA_W-1]) ? '0 : d;
  endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// Single-clock FIFO with count, zero head when empty, and push-on-full-with-pop.
module cnn_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; clear acts like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cnn_out_relu_pool.sv
// ReLU + max-pool stage on the CNN_OUT stream, buffered through a small FIFO.
module cnn_out_relu_pool
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W     = CNN_DATA_W,
  parameter int unsigned POOL_N     = CNN_POOL_N,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SIGNED_IN  = 1
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Clear,
  input  logic                          In_Valid,
  input  logic [DATA_W-1:0]             In_Data,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic [DATA_W-1:0]             Out_Data,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
  output logic [$clog2(POOL_N)-1:0]     Pool_Idx,
  output logic                          Overflow
);

  localparam int unsigned IW = $clog2(POOL_N);
  localparam logic [IW-1:0] LAST_IDX = IW'(POOL_N - 1);

  logic [IW-1:0]     pool_idx_q;
  logic [DATA_W-1:0] max_q;
  logic              overflow_q;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] new_max;
  logic              push_req;
  logic              fifo_full;
  logic              fifo_empty;

  // ReLU: the package helper covers the standard width, other widths clamp inline.
  if (DATA_W == CNN_DATA_W) begin : g_relu_pkg
    always_comb r = relu(In_Data, SIGNED_IN != 0);
  end else begin : g_relu_local
    always_comb r = ((SIGNED_IN != 0) && In_Data[DATA_W-1]) ? '0 : In_Data;
  end

  // Running max including the current sample; the first sample of a window seeds it.
  always_comb begin
    new_max = max_q;
    if (pool_idx_q == '0) new_max = r;
    else if (r > max_q)   new_max = r;
  end

  assign push_req = In_Valid && (pool_idx_q == LAST_IDX);

  // Window counter, running max and sticky overflow; Clear wins over everything.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pool_idx_q <= '0;
      max_q      <= '0;
      overflow_q <= 1'b0;
    end else if (Clear) begin
      pool_idx_q <= '0;
      max_q      <= '0;
      overflow_q <= 1'b0;
    end else if (In_Valid) begin
      max_q      <= new_max;
      pool_idx_q <= (pool_idx_q == LAST_IDX) ? '0 : pool_idx_q + 1'b1;
      if (push_req && fifo_full && !(Out_Ready && !fifo_empty))
        overflow_q <= 1'b1;
    end
  end

  cnn_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .clear (Clear),
    .push  (push_req),
    .pop   (Out_Ready),
    .din   (new_max),
    .head  (Out_Data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (Fifo_Count)
  );

  assign Out_Valid = !fifo_empty;
  assign Pool_Idx  = pool_idx_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_cnn_out_relu_pool.sv
// Directed bench for cnn_out_relu_pool with hand-computed expectations.
module tb_cnn_out_relu_pool;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Clear = 1'b0;
  logic        In_Valid = 1'b0;
  logic [15:0] In_Data = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [15:0] Out_Data;
  logic [3:0]  Fifo_Count;
  logic [1:0]  Pool_Idx;
  logic        Overflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  cnn_out_relu_pool #(
    .DATA_W     (16),
    .POOL_N     (4),
    .FIFO_DEPTH (8),
    .SIGNED_IN  (1)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Clear      (Clear),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Data   (Out_Data),
    .Fifo_Count (Fifo_Count),
    .Pool_Idx   (Pool_Idx),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    In_Valid = 1'b1;
    In_Data  = d;
    tick();
  endtask

  task automatic idle();
    In_Valid = 1'b0;
    tick();
  endtask

  // window whose max is m (m >= 10)
  task automatic window(input logic [15:0] m);
    send(m - 16'd5);
    send(m);
    send(16'd1);
    send(m - 16'd1);
  endtask

  initial begin
    logic [15:0] exp5 [8];

    // 1: reset state and basic window
    tick();
    tick();
    check("rst_valid", {31'b0, Out_Valid}, 32'd0);
    check("rst_data", {16'b0, Out_Data}, 32'd0);
    check("rst_count", {28'b0, Fifo_Count}, 32'd0);
    check("rst_idx", {30'b0, Pool_Idx}, 32'd0);
    check("rst_ovf", {31'b0, Overflow}, 32'd0);
    Rst = 1'b0;
    Out_Ready = 1'b1;
    send(16'd1);
    send(16'd2);
    send(16'd3);
    check("t1_idx3", {30'b0, Pool_Idx}, 32'd3);
    check("t1_novalid", {31'b0, Out_Valid}, 32'd0);
    send(16'd4);
    check("t1_valid", {31'b0, Out_Valid}, 32'd1);
    check("t1_data", {16'b0, Out_Data}, 32'd4);
    check("t1_idx0", {30'b0, Pool_Idx}, 32'd0);
    idle();
    check("t1_valid_drop", {31'b0, Out_Valid}, 32'd0);
    check("t1_count0", {28'b0, Fifo_Count}, 32'd0);

    // 2: negative clamp
    send(16'hFFFB);
    send(16'hFFFF);
    send(16'h8000);
    send(16'hFFFE);
    check("t2_valid_a", {31'b0, Out_Valid}, 32'd1);
    check("t2_data_a", {16'b0, Out_Data}, 32'h0000);
    send(16'h8000);
    send(16'h0005);
    send(16'h7FFF);
    send(16'h0003);
    check("t2_data_b", {16'b0, Out_Data}, 32'h7FFF);
    check("t2_count_b", {28'b0, Fifo_Count}, 32'd1);
    idle();
    check("t2_drained", {28'b0, Fifo_Count}, 32'd0);

    // 3: gapped input
    send(16'd9);
    idle();
    idle();
    send(16'd2);
    idle();
    send(16'd7);
    check("t3_pending", {31'b0, Out_Valid}, 32'd0);
    check("t3_idx", {30'b0, Pool_Idx}, 32'd3);
    send(16'd11);
    check("t3_valid", {31'b0, Out_Valid}, 32'd1);
    check("t3_data", {16'b0, Out_Data}, 32'd11);
    idle();

    // 4: overflow with stalled consumer
    Out_Ready = 1'b0;
    for (int w = 0; w < 8; w++) window(16'(10 + w));
    check("t4_count8", {28'b0, Fifo_Count}, 32'd8);
    check("t4_no_ovf_yet", {31'b0, Overflow}, 32'd0);
    window(16'd18);
    check("t4_count_full", {28'b0, Fifo_Count}, 32'd8);
    check("t4_ovf", {31'b0, Overflow}, 32'd1);
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t4_drain", {16'b0, Out_Data}, 32'(10 + k));
      tick();
    end
    check("t4_empty", {31'b0, Out_Valid}, 32'd0);
    check("t4_ovf_sticky", {31'b0, Overflow}, 32'd1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("t4_ovf_cleared", {31'b0, Overflow}, 32'd0);

    // 5: full FIFO with simultaneous push and pop
    Out_Ready = 1'b0;
    for (int w = 0; w < 8; w++) window(16'(20 + w));
    check("t5_full", {28'b0, Fifo_Count}, 32'd8);
    send(16'd50);
    send(16'd1);
    send(16'd2);
    Out_Ready = 1'b1;
    send(16'd3);
    check("t5_count", {28'b0, Fifo_Count}, 32'd8);
    check("t5_ovf", {31'b0, Overflow}, 32'd0);
    In_Valid = 1'b0;
    for (int k = 0; k < 7; k++) exp5[k] = 16'(21 + k);
    exp5[7] = 16'd50;
    for (int k = 0; k < 8; k++) begin
      check("t5_drain", {16'b0, Out_Data}, {16'b0, exp5[k]});
      tick();
    end
    check("t5_empty", {28'b0, Fifo_Count}, 32'd0);

    // 6: asynchronous reset mid-window with entries queued
    Out_Ready = 1'b0;
    window(16'd30);
    window(16'd31);
    window(16'd32);
    send(16'd40);
    send(16'd41);
    check("t6_count3", {28'b0, Fifo_Count}, 32'd3);
    check("t6_idx2", {30'b0, Pool_Idx}, 32'd2);
    In_Valid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, Out_Valid}, 32'd0);
    check("t6_rst_data", {16'b0, Out_Data}, 32'd0);
    check("t6_rst_count", {28'b0, Fifo_Count}, 32'd0);
    check("t6_rst_idx", {30'b0, Pool_Idx}, 32'd0);
    #2 Rst = 1'b0;
    Out_Ready = 1'b1;
    send(16'd6);
    send(16'd1);
    send(16'd1);
    check("t6_no_early", {31'b0, Out_Valid}, 32'd0);
    send(16'd1);
    check("t6_data", {16'b0, Out_Data}, 32'd6);
    idle();

    // 7: Clear discards a sample presented with it
    send(16'd70);
    send(16'd71);
    Clear = 1'b1;
    send(16'd99);
    Clear = 1'b0;
    check("t7_idx_cleared", {30'b0, Pool_Idx}, 32'd0);
    send(16'd5);
    send(16'd5);
    send(16'd5);
    check("t7_no_output", {31'b0, Out_Valid}, 32'd0);
    send(16'd5);
    check("t7_data", {16'b0, Out_Data}, 32'd5);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
